pipeline_ctrl: RTL and testbench

Central sequencer for the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It drives every latch enable/flush pair from four inputs: cache handshakes (ihit, dhit), load-use hazards, taken branches resolved at EX/MEM, and halt. An internal FSM covers the multi-cycle data-memory wait and the halt drain. It also keeps saturating stall and flush performance counters. It sits beside the datapath in the pipelined CPU top level.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/pipeline_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline-control FSM states
// and the NOP encoding that latch flushes load.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DMEM_WAIT,
        HALT_DRAIN,
        HALTED
    } pctrl_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones, never wraps.
// Ports: CLK, RST (async high), inc, clear (sync), cnt.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: drives PC and latch enable/flush pairs from
// cache handshakes, load-use hazards, taken branches and halt.
// Ports: CLK/RST, ihit/dhit, EX/MEM mem+halt flags, branch_taken,
// ID/EX load info, IF/ID sources -> pc_en, *_en, *_flush, halt,
// stall_cnt, flush_cnt.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_halt,
    input  logic             branch_taken,
    input  logic             idex_dREN,
    input  regbits_t         idex_wsel,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    pctrl_state_t  state, state_nx;
    logic [DW-1:0] drain, drain_nx;
    logic          memop, dstall, load_use, br_ev, stall_ev;

    assign memop    = exmem_dREN | exmem_dWEN;
    assign load_use = idex_dREN && (idex_wsel != '0) &&
                      ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    // In DMEM_WAIT the access is still outstanding whatever EX/MEM shows
    assign dstall   = (state == DMEM_WAIT) ? !dhit : (memop && !dhit);

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        state_nx    = state;
        drain_nx    = drain;
        br_ev       = 1'b0;
        unique case (state)
            RUN, DMEM_WAIT: begin
                if (dstall) begin
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                    state_nx    = DMEM_WAIT;
                end else begin
                    state_nx = RUN;
                    memwb_en = 1'b1;
                    exmem_en = 1'b1;
                    idex_en  = 1'b1;
                    ifid_en  = 1'b1;
                    if (exmem_halt) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        drain_nx    = DW'(DRAIN_CYCLES - 1);
                        state_nx    = HALT_DRAIN;
                    end else if (branch_taken) begin
                        pc_en       = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        br_ev       = 1'b1;
                    end else if (load_use) begin
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            HALT_DRAIN: begin
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                if (drain == '0) begin
                    state_nx = HALTED;
                end else begin
                    drain_nx = drain - DW'(1);
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            drain <= '0;
            halt  <= 1'b0;
        end else begin
            state <= state_nx;
            drain <= drain_nx;
            halt  <= (state_nx == HALTED);
        end
    end

    assign stall_ev = ((state == RUN) || (state == DMEM_WAIT)) && !pc_en;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_ev),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (br_ev),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random stimulus,
// all checked each cycle against a priority-rule model.
module tb_pipeline_ctrl;
    import cpu_types_pkg::*;

    localparam int DR = 2;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt;
    logic          branch_taken, idex_dREN;
    regbits_t      idex_wsel, ifid_rs, ifid_rt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic          halt;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [8:0]    dut_o;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.DRAIN_CYCLES(DR), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .exmem_halt(exmem_halt), .branch_taken(branch_taken),
        .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign dut_o = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush};

    // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
    localparam logic [8:0] P_DSTALL = 9'b0000_1_0001;
    localparam logic [8:0] P_HALT   = 9'b0111_1_1110;
    localparam logic [8:0] P_BR     = 9'b1111_1_1110;
    localparam logic [8:0] P_LU     = 9'b0011_1_0100;
    localparam logic [8:0] P_NOIH   = 9'b0111_1_1000;
    localparam logic [8:0] P_RUN    = 9'b1111_1_0000;

    int checks = 0;
    int failures = 0;

    // model: mode 0 run, 1 waiting on dmem, 2 draining, 3 halted
    int m_mode, m_left, m_sc, m_fc;
    logic [8:0] o_vec;
    logic       o_halt;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // 0 halted, 1 drain, 2 dmem stall, 3 halt, 4 branch, 5 load-use, 6 no ihit, 7 run
    function automatic int m_cat();
        logic busy;
        logic lu;
        if (m_mode == 3) return 0;
        if (m_mode == 2) return 1;
        busy = (m_mode == 1) ? !dhit : ((exmem_dREN || exmem_dWEN) && !dhit);
        lu = idex_dREN && idex_wsel != 0 &&
             (idex_wsel == ifid_rs || idex_wsel == ifid_rt);
        if (busy) return 2;
        if (exmem_halt) return 3;
        if (branch_taken) return 4;
        if (lu) return 5;
        if (!ihit) return 6;
        return 7;
    endfunction

    function automatic logic [8:0] exp_out();
        case (m_cat())
            0: return 9'b0;
            1: return P_HALT;
            2: return P_DSTALL;
            3: return P_HALT;
            4: return P_BR;
            5: return P_LU;
            6: return P_NOIH;
            default: return P_RUN;
        endcase
    endfunction

    task automatic compare_now();
        check("outs", int'(dut_o), int'(exp_out()));
        check("halt", int'(halt), int'(m_mode == 3));
        check("stall_cnt", int'(stall_cnt), m_sc);
        check("flush_cnt", int'(flush_cnt), m_fc);
    endtask

    task automatic model_step();
        int c;
        logic [8:0] p;
        c = m_cat();
        p = exp_out();
        if (m_mode < 2 && !p[8] && m_sc < CMAX) m_sc++;
        if (c == 4 && m_fc < CMAX) m_fc++;
        case (c)
            0: ;
            1: begin
                m_left--;
                if (m_left == 0) m_mode = 3;
            end
            2: m_mode = 1;
            3: begin
                m_mode = 2;
                m_left = DR;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic drive(input logic ih, input logic dh, input logic rd,
                         input logic wr, input logic xh, input logic br,
                         input logic ld, input int ws, input int rs,
                         input int rt);
        ihit = ih;
        dhit = dh;
        exmem_dREN = rd;
        exmem_dWEN = wr;
        exmem_halt = xh;
        branch_taken = br;
        idex_dREN = ld;
        idex_wsel = regbits_t'(ws);
        ifid_rs = regbits_t'(rs);
        ifid_rt = regbits_t'(rt);
    endtask

    task automatic cyc(input logic ih, input logic dh, input logic rd,
                       input logic wr, input logic xh, input logic br,
                       input logic ld, input int ws, input int rs,
                       input int rt);
        drive(ih, dh, rd, wr, xh, br, ld, ws, rs, rt);
        #1;
        compare_now();
        o_vec = dut_o;
        o_halt = halt;
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #1;
        m_mode = 0;
        m_left = 0;
        m_sc = 0;
        m_fc = 0;
        compare_now();
        check("rst_en", int'(dut_o), int'(9'h1F0));
        check("rst_halt", int'(halt), 0);
        check("rst_stall", int'(stall_cnt), 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mw;
        RST = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        do_reset();

        // reset while waiting on data memory
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // load stall: three busy cycles then dhit
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            check("ld_pc", int'(o_vec[8]), 0);
            check("ld_mwflush", int'(o_vec[0]), 1);
        end
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("ld_done", int'(o_vec), int'(9'h1F0));
        check("ld_cnt", int'(stall_cnt), 3);

        // load-use on rt, then wsel=0 never hazards
        cyc(1, 0, 0, 0, 0, 0, 1, 8, 3, 8);
        check("lu", int'(o_vec), int'(9'h074));
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("lu_r0", int'(o_vec), int'(9'h1F0));

        // taken branch beats missing ihit and load-use
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("br", int'(o_vec), int'(9'h1FE));
        check("br_cnt", int'(flush_cnt), 1);
        cyc(1, 0, 0, 0, 0, 1, 1, 8, 8, 2);
        check("br_lu", int'(o_vec), int'(9'h1FE));
        check("br_cnt2", int'(flush_cnt), 2);

        // halt drain
        do_reset();
        mw = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, 0, (i == 0), 0, 0, 0, 0, 0);
            if (i < 3) begin
                check("hd_vec", int'(o_vec), int'(9'h0FE));
                check("hd_halt", int'(o_halt), 0);
                mw += int'(o_vec[4]);
            end else begin
                check("hd_off", int'(o_vec), 0);
                check("hd_halted", int'(o_halt), 1);
            end
        end
        check("hd_mw", mw, 3);

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat", int'(stall_cnt), 15);

        // random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (m_mode == 3 && ($urandom % 4 == 0)) begin
                do_reset();
            end else begin
                cyc(($urandom % 4) != 0, ($urandom % 3) != 0,
                    ($urandom % 4) == 0, ($urandom % 8) == 0,
                    ($urandom % 50) == 0, ($urandom % 6) == 0,
                    ($urandom % 3) == 0, int'($urandom % 4),
                    int'($urandom % 4), int'($urandom % 4));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
